instr_seq_ctrl: RTL and testbench

Multi-cycle instruction sequencer for the RISC core. It accepts one instruction opcode at a time from the fetch stage and steps the shared datapath through DECODE, EXEC, MEM and WB. It produces the cycle-level strobes (IR load, PC enable/select, register-file write, memory request) that qualify the static signals from `control_unit`. It sits between fetch and the datapath and owns the only PC-advance decision.

---
 rtl/seq_pkg.sv | 49 ++++
 rtl/seq_timeout_cnt.sv | 34 +++
 rtl/instr_seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_instr_seq_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_pkg
// Brief    : Opcode constants, state/class enums and opcode classifier shared
//            by instr_seq_ctrl and control_unit.
// Revision : 1.0
// ============================================================================
package seq_pkg;

    localparam logic [5:0] OP_RTYPE   = 6'b000000;
    localparam logic [5:0] OP_STORE   = 6'b100000;
    localparam logic [5:0] OP_IALU_LO = 6'b010000;
    localparam logic [5:0] OP_IALU_HI = 6'b010101;
    localparam logic [5:0] OP_BR_LO   = 6'b001000;
    localparam logic [5:0] OP_BR_HI   = 6'b001111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } seq_state_t;

    typedef enum logic [2:0] {
        C_RALU    = 3'd0,
        C_IALU    = 3'd1,
        C_STORE   = 3'd2,
        C_BRANCH  = 3'd3,
        C_ILLEGAL = 3'd4
    } seq_class_t;

    function automatic seq_class_t decode_class(input logic [5:0] op);
        seq_class_t cls;
        if (op == OP_RTYPE)
            cls = C_RALU;
        else if (op >= OP_IALU_LO && op <= OP_IALU_HI)
            cls = C_IALU;
        else if (op == OP_STORE)
            cls = C_STORE;
        else if (op >= OP_BR_LO && op <= OP_BR_HI)
            cls = C_BRANCH;
        else
            cls = C_ILLEGAL;
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module   : seq_timeout_cnt
// Brief    : MEM-phase wait counter; expired flags the last permitted cycle.
// Revision : 1.0
// ============================================================================
module seq_timeout_cnt #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int c_width = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [c_width-1:0] c_last = c_width'(MEM_TIMEOUT - 1);

    logic [c_width-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (clr)
            r_cnt <= '0;
        else if (en)
            r_cnt <= r_cnt + 1'b1;
    end

    assign expired = en && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/instr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : instr_seq_ctrl
// Brief    : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer producing datapath
//            strobes. Define SEQ_PERF_EN to add cycle/retired counters.
// Revision : 1.0
// ============================================================================
module instr_seq_ctrl
    import seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [5:0]  opcode,
    input  logic        branch_cond,
    input  logic        mem_ack,
    output logic        ir_load,
    output logic        pc_en,
    output logic        pc_src,
    output logic        rf_we,
    output logic        mem_req,
    output logic        illegal,
    output logic        mem_err,
    output logic        busy
`ifdef SEQ_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] retired_cnt
`endif
);

    seq_state_t r_state, w_next;
    seq_class_t r_class, w_cls_dec;
    logic [5:0] r_opcode;
    logic       r_mem_err;

    logic w_ready, w_ir_load, w_pc_en, w_pc_src, w_rf_we, w_mem_req, w_illegal;
    logic w_tmo_clr, w_tmo_en, w_expired, w_set_err;

    assign w_cls_dec = decode_class(r_opcode);

    seq_timeout_cnt #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_tmo_clr),
        .en      (w_tmo_en),
        .expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_class   <= C_ILLEGAL;
            r_opcode  <= '0;
            r_mem_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH && instr_valid)
                r_opcode <= opcode;
            if (r_state == S_DECODE)
                r_class <= w_cls_dec;
            if (w_set_err)
                r_mem_err <= 1'b1;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_ready   = 1'b0;
        w_ir_load = 1'b0;
        w_pc_en   = 1'b0;
        w_pc_src  = 1'b0;
        w_rf_we   = 1'b0;
        w_mem_req = 1'b0;
        w_illegal = 1'b0;
        w_tmo_clr = 1'b0;
        w_tmo_en  = 1'b0;
        w_set_err = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ready   = 1'b1;
                w_ir_load = instr_valid;
                if (instr_valid)
                    w_next = S_DECODE;
            end
            S_DECODE: begin
                if (w_cls_dec == C_ILLEGAL) begin
                    w_illegal = 1'b1;
                    w_pc_en   = 1'b1;
                    w_next    = S_FETCH;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                case (r_class)
                    C_RALU, C_IALU: w_next = S_WB;
                    C_STORE: begin
                        w_tmo_clr = 1'b1;
                        w_next    = S_MEM;
                    end
                    C_BRANCH: begin
                        w_pc_en  = 1'b1;
                        w_pc_src = branch_cond;
                        w_next   = S_FETCH;
                    end
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                w_mem_req = 1'b1;
                w_tmo_en  = 1'b1;
                // Ack is checked first so it wins over a coincident timeout.
                if (mem_ack) begin
                    w_pc_en = 1'b1;
                    w_next  = S_FETCH;
                end else if (w_expired) begin
                    w_set_err = 1'b1;
                    w_pc_en   = 1'b1;
                    w_next    = S_FETCH;
                end
            end
            S_WB: begin
                w_rf_we = 1'b1;
                w_pc_en = 1'b1;
                w_next  = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Gating with ~rst makes every output fall asynchronously with reset.
    assign instr_ready = w_ready   & ~rst;
    assign ir_load     = w_ir_load & ~rst;
    assign pc_en       = w_pc_en   & ~rst;
    assign pc_src      = w_pc_src  & ~rst;
    assign rf_we       = w_rf_we   & ~rst;
    assign mem_req     = w_mem_req & ~rst;
    assign illegal     = w_illegal & ~rst;
    assign mem_err     = r_mem_err & ~rst;
    assign busy        = (r_state != S_FETCH) & ~rst;

`ifdef SEQ_PERF_EN
    logic [31:0] r_cycle_cnt, r_retired_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle_cnt   <= '0;
            r_retired_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (w_pc_en && !w_illegal && !w_set_err)
                r_retired_cnt <= r_retired_cnt + 32'd1;
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign retired_cnt = r_retired_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_seq_ctrl
// Brief    : Directed self-checking bench for instr_seq_ctrl (MEM_TIMEOUT = 4).
// Revision : 1.0
// ============================================================================
module tb_instr_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       instr_valid = 1'b0;
    logic [5:0] opcode = '0;
    logic       branch_cond = 1'b0;
    logic       mem_ack = 1'b0;
    logic       instr_ready, ir_load, pc_en, pc_src, rf_we, mem_req, illegal, mem_err, busy;
`ifdef SEQ_PERF_EN
    logic [31:0] cycle_cnt, retired_cnt;
`endif

    int checks = 0;
    int errors = 0;

    instr_seq_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .branch_cond (branch_cond),
        .mem_ack     (mem_ack),
        .ir_load     (ir_load),
        .pc_en       (pc_en),
        .pc_src      (pc_src),
        .rf_we       (rf_we),
        .mem_req     (mem_req),
        .illegal     (illegal),
        .mem_err     (mem_err),
        .busy        (busy)
`ifdef SEQ_PERF_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .retired_cnt (retired_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Vector bits: ready, ir_load, pc_en, pc_src, rf_we, mem_req, illegal, mem_err, busy
    function automatic logic [8:0] outs();
        return {instr_ready, ir_load, pc_en, pc_src, rf_we, mem_req, illegal, mem_err, busy};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // pc_src is only meaningful while pc_en is expected high.
    task automatic check_vec(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        obs = outs();
        if (!exp[6])
            obs[5] = 1'b0;
        check(tag, {23'd0, obs}, {23'd0, exp});
    endtask

    task automatic cyc(input string tag, input logic v, input logic [5:0] op,
                       input logic bc, input logic ack, input logic [8:0] exp);
        @(posedge clk);
        #1;
        instr_valid = v;
        opcode      = op;
        branch_cond = bc;
        mem_ack     = ack;
        #1;
        check_vec(tag, exp);
    endtask

    localparam logic [8:0] IDLE = 9'b1_0_0_0_0_0_0_0_0;
    localparam logic [8:0] HS   = 9'b1_1_0_0_0_0_0_0_0;
    localparam logic [8:0] BSY  = 9'b0_0_0_0_0_0_0_0_1;
    localparam logic [8:0] WB   = 9'b0_0_1_0_1_0_0_0_1;
    localparam logic [8:0] MEMW = 9'b0_0_0_0_0_1_0_0_1;
    localparam logic [8:0] MEMD = 9'b0_0_1_0_0_1_0_0_1;

    initial begin
        #3;
        check_vec("reset_outputs", 9'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 check_vec("post_reset_fetch", IDLE);

        // RALU, with stray instr_valid and mem_ack outside their states
        cyc("ralu_hs",   1, 6'b000000, 0, 0, HS);
        cyc("ralu_dec",  1, 6'b111111, 0, 1, BSY);
        cyc("ralu_exec", 0, 6'b000000, 0, 1, BSY);
        cyc("ralu_wb",   0, 6'b000000, 0, 0, WB);
        cyc("ralu_rdy",  0, 6'b000000, 0, 0, IDLE);

        cyc("br1_hs",   1, 6'b001010, 0, 0, HS);
        cyc("br1_dec",  0, 6'b000000, 0, 0, BSY);
        cyc("br1_exec", 0, 6'b000000, 1, 0, 9'b0_0_1_1_0_0_0_0_1);
        cyc("br1_rdy",  0, 6'b000000, 0, 0, IDLE);

        cyc("br0_hs",   1, 6'b001111, 0, 0, HS);
        cyc("br0_dec",  0, 6'b000000, 1, 0, BSY);
        cyc("br0_exec", 0, 6'b000000, 0, 0, 9'b0_0_1_0_0_0_0_0_1);
        cyc("br0_rdy",  0, 6'b000000, 0, 0, IDLE);

        cyc("ialu_hs",   1, 6'b010101, 0, 0, HS);
        cyc("ialu_dec",  0, 6'b000000, 0, 0, BSY);
        cyc("ialu_exec", 0, 6'b000000, 0, 0, BSY);
        cyc("ialu_wb",   0, 6'b000000, 0, 0, WB);
        cyc("ialu_rdy",  0, 6'b000000, 0, 0, IDLE);

        cyc("ill_hs",  1, 6'b111111, 0, 0, HS);
        cyc("ill_dec", 0, 6'b000000, 0, 0, 9'b0_0_1_0_0_0_1_0_1);
        cyc("ill_rdy", 0, 6'b000000, 0, 0, IDLE);
        cyc("ill2_hs",  1, 6'b010110, 0, 0, HS);
        cyc("ill2_dec", 0, 6'b000000, 0, 0, 9'b0_0_1_0_0_0_1_0_1);
        cyc("ill2_rdy", 0, 6'b000000, 0, 0, IDLE);

        // Store acked on the third MEM cycle
        cyc("st_hs",   1, 6'b100000, 0, 0, HS);
        cyc("st_dec",  0, 6'b000000, 0, 0, BSY);
        cyc("st_exec", 0, 6'b000000, 0, 0, BSY);
        cyc("st_mem3", 0, 6'b000000, 0, 0, MEMW);
        cyc("st_mem4", 0, 6'b000000, 0, 0, MEMW);
        cyc("st_mem5", 0, 6'b000000, 0, 1, MEMD);
        cyc("st_rdy",  0, 6'b000000, 0, 0, IDLE);

        // Store acked on the expiry cycle: ack wins
        cyc("sta_hs",   1, 6'b100000, 0, 0, HS);
        cyc("sta_dec",  0, 6'b000000, 0, 0, BSY);
        cyc("sta_exec", 0, 6'b000000, 0, 0, BSY);
        cyc("sta_mem3", 0, 6'b000000, 0, 0, MEMW);
        cyc("sta_mem4", 0, 6'b000000, 0, 0, MEMW);
        cyc("sta_mem5", 0, 6'b000000, 0, 0, MEMW);
        cyc("sta_mem6", 0, 6'b000000, 0, 1, MEMD);
        cyc("sta_rdy",  0, 6'b000000, 0, 0, IDLE);

        // Store timeout, no ack
        cyc("sto_hs",   1, 6'b100000, 0, 0, HS);
        cyc("sto_dec",  0, 6'b000000, 0, 0, BSY);
        cyc("sto_exec", 0, 6'b000000, 0, 0, BSY);
        cyc("sto_mem3", 0, 6'b000000, 0, 0, MEMW);
        cyc("sto_mem4", 0, 6'b000000, 0, 0, MEMW);
        cyc("sto_mem5", 0, 6'b000000, 0, 0, MEMW);
        cyc("sto_mem6", 0, 6'b000000, 0, 0, MEMD);
        cyc("sto_rdy",  0, 6'b000000, 0, 0, 9'b1_0_0_0_0_0_0_1_0);

        // mem_err stays set through a following RALU
        cyc("stk_hs",   1, 6'b000000, 0, 0, 9'b1_1_0_0_0_0_0_1_0);
        cyc("stk_dec",  0, 6'b000000, 0, 0, 9'b0_0_0_0_0_0_0_1_1);
        cyc("stk_exec", 0, 6'b000000, 0, 0, 9'b0_0_0_0_0_0_0_1_1);
        cyc("stk_wb",   0, 6'b000000, 0, 0, 9'b0_0_1_0_1_0_0_1_1);
        cyc("stk_rdy",  0, 6'b000000, 0, 0, 9'b1_0_0_0_0_0_0_1_0);
`ifdef SEQ_PERF_EN
        check("retired_before_rst", retired_cnt, 32'd7);
`endif

        // Reset while in MEM
        cyc("rs_hs",   1, 6'b100000, 0, 0, 9'b1_1_0_0_0_0_0_1_0);
        cyc("rs_dec",  0, 6'b000000, 0, 0, 9'b0_0_0_0_0_0_0_1_1);
        cyc("rs_exec", 0, 6'b000000, 0, 0, 9'b0_0_0_0_0_0_0_1_1);
        cyc("rs_mem",  0, 6'b000000, 0, 0, 9'b0_0_0_0_0_1_0_1_1);
        #1 rst = 1'b1;
        #1 check_vec("rs_async_drop", 9'b0);
        @(posedge clk);
        #1 check_vec("rs_held", 9'b0);
`ifdef SEQ_PERF_EN
        check("retired_after_rst", retired_cnt, 32'd0);
`endif
        rst = 1'b0;
        #1 check_vec("rs_release_fetch", IDLE);
`ifdef SEQ_PERF_EN
        check("cycle_after_rst", cycle_cnt, 32'd0);
`endif
        cyc("rs_idle", 0, 6'b000000, 0, 0, IDLE);
`ifdef SEQ_PERF_EN
        check("cycle_count_1", cycle_cnt, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
